// File: rtl/y_mux_pkg.sv
// Shared definitions for the y_mux_arb arbitrating multiplexer:
// grant-mode encodings and a small index helper.
package y_mux_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'd0;
    localparam logic [1:0] MODE_PRIO   = 2'd1;
    localparam logic [1:0] MODE_RR     = 2'd2;

    // Successor of channel index g in a ring of n channels.
    function automatic int next_idx(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/y_mux_arb_if.sv
// Producer/consumer bundle of y_mux_arb: NCH input streams, arbitration
// controls and the single merged output stream.
interface y_mux_arb_if #(
    parameter int W   = 32,
    parameter int NCH = 4
);
    localparam int SELW = $clog2(NCH);

    logic [1:0]       mode;
    logic [SELW-1:0]  sel;
    logic [NCH*W-1:0] in_data;
    logic [NCH-1:0]   in_valid;
    logic [NCH-1:0]   in_ready;
    logic [W-1:0]     out_data;
    logic [SELW-1:0]  out_chan;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

endinterface

// File: rtl/y_rr_pick.sv
// Rotating priority picker: first requesting channel at or after start,
// wrapping from NCH-1 back to 0.
module y_rr_pick #(
    parameter  int NCH  = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] start,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);

    logic [NCH-1:0] rot;
    int             off;

    // rot[k] is the request k positions after start.
    always_comb begin
        rot = '0;
        for (int k = 0; k < NCH; k++) begin
            rot[k] = req[(int'(start) + k) % NCH];
        end
    end

    always_comb begin
        gnt_any = 1'b0;
        off     = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_any = 1'b1;
                off     = k;
            end
        end
        gnt_idx = SELW'((int'(start) + off) % NCH);
    end

endmodule

// File: rtl/y_mux_arb.sv
// NCH-channel arbitrating multiplexer with a one-entry registered output;
// grant by direct select, fixed priority or round-robin.
module y_mux_arb
    import y_mux_pkg::*;
#(
    parameter int W   = 32,
    parameter int NCH = 4
) (
    input logic         clk,
    input logic         rst_n,
    y_mux_arb_if.slave  bus
);

    localparam int SELW = $clog2(NCH);

    logic [W-1:0]    data_p0;
    logic [SELW-1:0] chan_p0;
    logic            vld_p0;
    logic [SELW-1:0] ptr;

    logic            load_en;
    logic            grant_valid;
    logic            xfer;
    logic [SELW-1:0] g;
    logic [SELW:0]   sel_ext;
    logic [SELW-1:0] prio_idx;
    logic            prio_any;
    logic [SELW-1:0] rr_idx;
    logic            rr_any;

    y_rr_pick #(.NCH(NCH)) u_prio (
        .req     (bus.in_valid),
        .start   ('0),
        .gnt_idx (prio_idx),
        .gnt_any (prio_any)
    );

    y_rr_pick #(.NCH(NCH)) u_rr (
        .req     (bus.in_valid),
        .start   (ptr),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    assign sel_ext = {1'b0, bus.sel};
    assign load_en = !vld_p0 || bus.out_ready;

    // Mode mux: modes 2 and 3 both select round-robin.
    always_comb begin
        g           = '0;
        grant_valid = 1'b0;
        case (bus.mode)
            MODE_DIRECT: begin
                g           = bus.sel;
                grant_valid = (sel_ext < (SELW + 1)'(NCH)) && bus.in_valid[bus.sel];
            end
            MODE_PRIO: begin
                g           = prio_idx;
                grant_valid = prio_any;
            end
            default: begin
                g           = rr_idx;
                grant_valid = rr_any;
            end
        endcase
    end

    assign xfer = load_en && grant_valid;

    always_comb begin
        bus.in_ready = '0;
        if (rst_n && xfer) begin
            bus.in_ready[g] = 1'b1;
        end
    end

    // Output register stage; ptr advances past whichever channel transferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            chan_p0 <= '0;
            ptr     <= '0;
        end else if (xfer) begin
            vld_p0  <= 1'b1;
            data_p0 <= bus.in_data[int'(g)*W +: W];
            chan_p0 <= g;
            ptr     <= SELW'(next_idx(int'(g), NCH));
        end else if (load_en) begin
            vld_p0  <= 1'b0;
        end
    end

    assign bus.out_data  = data_p0;
    assign bus.out_chan  = chan_p0;
    assign bus.out_valid = vld_p0;

endmodule

// File: tb/tb_y_mux_arb.sv
// Bench for y_mux_arb: directed scenarios plus a randomized run against a
// behavioural model with per-channel scoreboards.
module tb_y_mux_arb;

    localparam int W    = 32;
    localparam int NCH  = 4;
    localparam int SELW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    y_mux_arb_if #(.W(W), .NCH(NCH)) bus ();

    y_mux_arb #(.W(W), .NCH(NCH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int seqn  = 0;

    // Reference state: held output word, round-robin pointer, expected words per channel.
    bit           m_vld;
    logic [W-1:0] m_data;
    int           m_chan;
    int           m_ptr;
    logic [W-1:0] q[NCH][$];

    logic [NCH-1:0]  s_ready;
    logic            s_vld;
    logic [W-1:0]    s_data;
    logic [SELW-1:0] s_chan;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mkword(input int ch);
        logic [31:0] r;
        r = $urandom();
        seqn++;
        return {r[31:20], ch[3:0], seqn[15:0]};
    endfunction

    task automatic drive(input logic [1:0] md, input int sl, input logic [NCH-1:0] vl, input logic ordy);
        bus.mode      = md;
        bus.sel       = SELW'(sl);
        bus.in_valid  = vl;
        bus.out_ready = ordy;
        for (int ch = 0; ch < NCH; ch++) bus.in_data[ch*W +: W] = mkword(ch);
    endtask

    task automatic model_clear();
        m_vld  = 1'b0;
        m_data = '0;
        m_chan = 0;
        m_ptr  = 0;
        for (int ch = 0; ch < NCH; ch++) q[ch].delete();
    endtask

    // Entered at a falling edge with inputs driven; leaves at the next falling edge.
    task automatic cycle(input string tag);
        int           g;
        int           start;
        int           idx;
        bit           gv;
        bit           le;
        logic [NCH-1:0] er;
        logic [W-1:0] w;
        logic [W-1:0] exp_pop;
        #1;
        s_ready = bus.in_ready;
        s_vld   = bus.out_valid;
        s_data  = bus.out_data;
        s_chan  = bus.out_chan;
        le = !m_vld || bus.out_ready;
        gv = 1'b0;
        g  = 0;
        w  = '0;
        if (bus.mode == 2'd0) begin
            g  = int'(bus.sel);
            gv = (g < NCH) && bus.in_valid[g];
        end else begin
            start = (bus.mode == 2'd1) ? 0 : m_ptr;
            for (int k = 0; k < NCH; k++) begin
                idx = (start + k) % NCH;
                if (!gv && bus.in_valid[idx]) begin
                    gv = 1'b1;
                    g  = idx;
                end
            end
        end
        er = (le && gv) ? (NCH'(1) << g) : '0;
        check({tag, "_in_ready"}, 32'(s_ready), 32'(er));
        check({tag, "_out_valid"}, 32'(s_vld), 32'(m_vld));
        if (m_vld) begin
            check({tag, "_out_data"}, s_data, m_data);
            check({tag, "_out_chan"}, 32'(s_chan), 32'(m_chan));
        end
        if (s_vld && bus.out_ready) begin
            exp_pop = (q[s_chan].size() > 0) ? q[s_chan].pop_front() : ~s_data;
            check({tag, "_sb_order"}, s_data, exp_pop);
        end
        if (le && gv) begin
            w = bus.in_data[g*W +: W];
            q[g].push_back(w);
        end
        @(posedge clk);
        if (le && gv) begin
            m_vld  = 1'b1;
            m_data = w;
            m_chan = g;
            m_ptr  = (g + 1) % NCH;
        end else if (le) begin
            m_vld = 1'b0;
        end
        @(negedge clk);
    endtask

    // Entered and left at a falling edge; reset asserted between edges.
    task automatic do_reset();
        bus.in_valid = '1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_chan", 32'(bus.out_chan), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int total;
        logic [W-1:0] hold;
        bus.mode      = 2'd0;
        bus.sel       = '0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_clear();
        @(negedge clk);
        do_reset();

        drive(2'd0, 2, 4'b0100, 1'b1);
        bus.in_data[2*W +: W] = 32'hDEADBEEF;
        cycle("t1");
        check("t1_grant_ch2", 32'(s_ready), 32'b0100);
        drive(2'd0, 2, 4'b0000, 1'b1);
        cycle("t1b");
        check("t1_data", s_data, 32'hDEADBEEF);
        check("t1_chan", 32'(s_chan), 32'd2);
        check("t1_valid", 32'(s_vld), 32'd1);

        for (int c = 0; c < 3; c++) begin
            drive(2'd1, 0, 4'b1010, 1'b1);
            cycle("t2");
            check("t2_prio_ch1", 32'(s_ready), 32'b0010);
        end

        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(2'd2, 0, 4'b1111, 1'b1);
            cycle("t3");
            if (c >= 1) check("t3_rr_seq", 32'(s_chan), 32'((c - 1) % NCH));
        end
        for (int c = 0; c < 3; c++) begin
            drive(2'd2, 0, 4'b1111, 1'b1);
            cycle("t3m");
        end
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(2'd2, 0, 4'b1111, 1'b1);
            cycle("t3r");
            if (c >= 1) check("t3_rr_restart", 32'(s_chan), 32'(c - 1));
        end

        drive(2'd2, 0, 4'b1111, 1'b1);
        cycle("t4load");
        hold = m_data;
        for (int c = 0; c < 4; c++) begin
            drive(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), NCH'($urandom()) | 4'b0001, 1'b0);
            cycle("t4");
            check("t4_stall_ready", 32'(s_ready), 32'd0);
            check("t4_stall_data", s_data, hold);
        end
        drive(2'd1, 0, 4'b1000, 1'b1);
        cycle("t4rel");
        check("t4_release_ready", 32'(s_ready), 32'b1000);
        drive(2'd0, 1, 4'b1101, 1'b1);
        cycle("t4next");
        check("t4_next_chan", 32'(s_chan), 32'd3);

        drive(2'd0, 1, 4'b1101, 1'b1);
        cycle("t5");
        check("t5_no_grant", 32'(s_ready), 32'd0);
        check("t5_valid_falls", 32'(s_vld), 32'd0);

        for (int i = 0; i < 1000; i++) begin
            if (i == 500) do_reset();
            drive(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), NCH'($urandom()),
                  $urandom_range(0, 3) != 0);
            cycle("rnd");
        end

        for (int c = 0; c < 3; c++) begin
            drive(2'd0, 0, 4'b0000, 1'b1);
            cycle("drain");
        end
        total = 0;
        for (int ch = 0; ch < NCH; ch++) total += q[ch].size();
        check("sb_all_delivered", 32'(total), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/y_mux_arb.md
# y_mux_arb

Parametrised N-channel, W-bit arbitrating multiplexer: the registered, handshaked successor to the combinational 4-to-1 word mux. It merges NCH valid/ready input streams into one registered output stream. The grant is chosen by a runtime mode: direct select, fixed priority, or round-robin. It sits between multiple producers (e.g. register-file read ports, ALU result sources) and a single consumer stage.

## Interface
- W, 32, data width per channel
- NCH, 4, number of input channels (2..16)
- SELW, $clog2(NCH), derived: channel index width; not overridden
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- mode  in  2  0 = direct select, 1 = fixed priority (lowest index wins), 2/3 = round-robin
- sel  in  SELW  channel index used in mode 0
- in_data  in  NCH*W  channel i occupies bits [i*W+W-1 : i*W]
- in_valid  in  NCH  per-channel valid
- in_ready  out  NCH  per-channel ready; at most one bit high per cycle
- out_data  out  W  registered selected word
- out_chan  out  SELW  index of the channel that supplied out_data
- out_valid  out  1  output word held
- out_ready  in  1  consumer accepts

## Operation
- One-entry output register. load_en = !out_valid || out_ready.
- Arbitration each cycle (combinational) produces a grant g and a grant_valid:
  - mode 0: grant_valid = in_valid[sel]; g = sel. sel >= NCH gives grant_valid = 0.
  - mode 1: g = lowest i with in_valid[i].
  - mode 2/3: g = first i with in_valid[i], searching from ptr upward, wrapping at NCH-1 to 0.
- in_ready[g] = load_en && grant_valid. All other in_ready bits are 0.
- Transfer on channel g when in_valid[g] && in_ready[g]. On the next edge: out_data <= word g, out_chan <= g, out_valid <= 1.
- If load_en && !grant_valid: out_valid <= 0 on the next edge, if the held word drained.
- Round-robin pointer ptr (SELW bits). On each transfer in any mode, ptr <= (g+1) mod NCH; wraps from NCH-1 to 0. ptr is otherwise held.
- mode and sel changes take effect in the same cycle's arbitration and never alter a held output word.
- Non-valid channels are never granted. in_valid is not required to stay high without ready; no channel is starved in round-robin mode.

## Timing
- Reset (async assert, sync-release use): out_valid = 0, out_data = 0, out_chan = 0, ptr = 0, in_ready = 0.
- Latency: input transfer at edge k gives out_valid = 1 with that data after edge k.
- Throughput: 1 word/cycle when out_ready is held high. Simultaneous drain and load in one cycle is required, with no bubble.
- Back-pressure: while out_valid && !out_ready, out_data and out_chan are stable and all in_ready = 0.
- in_ready depends combinationally on out_ready, in_valid, mode and sel. There is no combinational path from in_data to any output.
- Reset asserted mid-stream discards the held word. The first grant after reset is at channel 0 priority.

## Structure
- Package y_mux_pkg holds MODE_DIRECT = 2'd0, MODE_PRIO = 2'd1 and MODE_RR = 2'd2 as localparams.
- Sub-module y_rr_pick (parameter NCH):
  - inputs: req[NCH], start[SELW]
  - outputs: gnt_idx, gnt_any
  - rotate-and-priority-encode.
- Mode 1 reuses y_rr_pick with start = 0.
- The top level holds the mode mux, the output register and ptr.

## Test plan
- Reset, then mode 0, sel = 2, in_valid = 4'b0100, in_data ch2 = 32'hDEADBEEF, out_ready = 1 -> in_ready = 4'b0100. Next cycle: out_data = DEADBEEF, out_chan = 2, out_valid = 1.
- Mode 1, in_valid = 4'b1010, out_ready = 1 for 3 cycles -> ch1 granted every cycle; ch3 never granted.
- Mode 2, in_valid = 4'b1111 held, out_ready = 1 -> out_chan sequence 0,1,2,3,0. After reset mid-sequence, the sequence restarts at 0.
- Back-pressure: out_valid = 1, out_ready = 0 for 4 cycles with changing inputs -> out_data constant, in_ready = 0. Drop out_ready's stall -> next word loads in the same cycle as the drain.
- Mode 0, sel = 1, in_valid = 4'b1101 -> no grant. Once the held word drains, out_valid falls to 0.
- Randomised 1000-cycle run, all modes, random out_ready, with a scoreboard per channel -> no loss, no duplication, per-channel order preserved.
